// File: rtl/fir_macc_sequencer.sv
// FIR sequencer that streams delay-line samples and coefficients into an external
// registered-input MAC, then rounds, saturates and hands off one result per sample.
module fir_macc_sequencer #(
   parameter int NTAPS = 8,
   parameter int SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_data,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic [15:0]              coef_data,
   output logic                     mac_clr,
   output logic [15:0]              mac_a,
   output logic [15:0]              mac_b,
   input  logic [47:0]              mac_acc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_data
);

   // state | meaning
   // IDLE  | waiting for a sample; coefficient writes allowed
   // CLEAR | one cycle of mac_clr to zero the MAC
   // FEED  | NTAPS cycles of sample/coefficient operands
   // DRAIN | two cycles for the MAC pipeline; result captured in the second
   // OUT   | result offered until out_ready
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

   localparam int AW = $clog2(NTAPS);
   localparam logic [AW-1:0] FEED_TC_LOAD  = AW'(NTAPS - 1);
   localparam logic [AW-1:0] DRAIN_TC_LOAD = AW'(1);

   state_t         state_q, state_d;
   logic [AW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  wr_ptr_q;
   logic [15:0]    out_data_q, out_data_d;
   logic [15:0]    dline_q [NTAPS];
   logic [15:0]    coef_q  [NTAPS];

   logic           accept;
   logic           coef_wr;
   logic [AW-1:0]  rd_idx;
   logic [AW-1:0]  coef_idx;
   logic [48:0]    rnd_sum;
   logic [48:0]    rnd_shr;
   logic [15:0]    sat_val;

   assign accept   = (state_q == S_IDLE) && in_valid;
   assign coef_wr  = (state_q == S_IDLE) && coef_we;

   // Down-counter c = NTAPS-1-k: newest-k == wr_ptr+c and k == ~c (power-of-two NTAPS).
   assign rd_idx   = wr_ptr_q + cnt_q;
   assign coef_idx = ~cnt_q;

   assign rnd_sum  = {1'b0, mac_acc} + (49'd1 << (SHIFT - 1));
   assign rnd_shr  = rnd_sum >> SHIFT;
   assign sat_val  = (|rnd_shr[48:16]) ? 16'hFFFF : rnd_shr[15:0];

   assign in_ready  = (state_q == S_IDLE);
   assign mac_clr   = (state_q == S_CLEAR);
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_data_q;
   assign mac_a     = (state_q == S_FEED) ? dline_q[rd_idx]  : 16'd0;
   assign mac_b     = (state_q == S_FEED) ? coef_q[coef_idx] : 16'd0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_FEED;
            cnt_d   = FEED_TC_LOAD;
         end
         S_FEED: begin
            if (cnt_q == '0) begin
               state_d = S_DRAIN;
               cnt_d   = DRAIN_TC_LOAD;
            end else begin
               cnt_d = cnt_q - AW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d    = S_OUT;
               out_data_d = sat_val;
            end else begin
               cnt_d = cnt_q - AW'(1);
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         out_data_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            dline_q[i] <= 16'd0;
            coef_q[i]  <= 16'd0;
         end
      end else begin
         if (accept) begin
            dline_q[wr_ptr_q] <= in_data;
            wr_ptr_q          <= wr_ptr_q + AW'(1);
         end
         if (coef_wr) coef_q[coef_addr] <= coef_data;
      end
   end

endmodule

// File: tb/tb_fir_macc_sequencer.sv
// Directed bench for fir_macc_sequencer with a behavioural registered-input MAC.
module tb_fir_macc_sequencer;
   localparam int NT = 8;
   localparam int SH = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'd0;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = 3'd0;
   logic [15:0] coef_data = 16'd0;
   logic        mac_clr;
   logic [15:0] mac_a, mac_b;
   logic [47:0] mac_acc;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;

   int total = 0;
   int bad   = 0;

   fir_macc_sequencer #(.NTAPS(NT), .SHIFT(SH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
      .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   always #5 clk = ~clk;

   // operands registered at edge, product accumulated one edge later
   logic [15:0] ma_r, mb_r;
   logic [47:0] acc_m;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_r <= '0; mb_r <= '0; acc_m <= '0;
      end else if (mac_clr) begin
         ma_r <= '0; mb_r <= '0; acc_m <= '0;
      end else begin
         ma_r  <= mac_a;
         mb_r  <= mac_b;
         acc_m <= acc_m + ({32'd0, ma_r} * {32'd0, mb_r});
      end
   end
   assign mac_acc = acc_m;

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      tick;
      coef_we = 1'b0;
   endtask

   // Offers one sample, checks latency and result, consumes it with out_ready=1.
   task automatic run_sample(input logic [15:0] s, input logic [15:0] exp, input string nm);
      int lat;
      in_valid = 1'b1; in_data = s;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready: got %0d want 1", nm, in_ready); end
      tick;
      in_valid = 1'b0;
      lat = 1;
      total++;
      if (mac_clr !== 1'b1) begin bad++; $display("FAIL %s mac_clr: got %0d want 1", nm, mac_clr); end
      while (out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      total++;
      if (lat !== NT + 4) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, NT + 4); end
      total++;
      if (out_data !== exp) begin bad++; $display("FAIL %s out_data: got %0d want %0d", nm, out_data, exp); end
      tick;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL %s return_idle: in_ready=%0d out_valid=%0d want 1/0", nm, in_ready, out_valid);
      end
   endtask

   task automatic test_reset;
      do_reset;
      total++;
      if ({in_ready, out_valid, mac_clr} !== 3'b100) begin
         bad++; $display("FAIL reset_ctrl: got in_ready/out_valid/mac_clr=%b want 100", {in_ready, out_valid, mac_clr});
      end
      total++;
      if (mac_a !== 16'd0 || mac_b !== 16'd0 || out_data !== 16'd0) begin
         bad++; $display("FAIL reset_data: got a=%0d b=%0d out=%0d want 0/0/0", mac_a, mac_b, out_data);
      end
   endtask

   task automatic test_impulse;
      do_reset;
      write_coef(3'd0, 16'd32768);
      run_sample(16'd1000, 16'd1000, "impulse");
   endtask

   task automatic test_delay_line;
      logic [15:0] xs [10];
      logic [15:0] ex [10];
      xs = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100};
      ex = '{16'd0, 16'd0, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
      do_reset;
      write_coef(3'd2, 16'd32768);
      for (int i = 0; i < 10; i++) run_sample(xs[i], ex[i], $sformatf("delay%0d", i));
   endtask

   task automatic test_round_sat;
      do_reset;
      write_coef(3'd0, 16'd16384);
      run_sample(16'd3, 16'd2, "round");
      for (int i = 0; i < NT; i++) write_coef(3'(i), 16'hFFFF);
      for (int i = 0; i < NT; i++) run_sample(16'hFFFF, 16'hFFFF, $sformatf("sat%0d", i));
   endtask

   task automatic test_same_cycle;
      do_reset;
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd32768;
      run_sample(16'd55, 16'd55, "same_cycle");
      coef_we = 1'b0;
   endtask

   task automatic test_back_pressure;
      int lat;
      do_reset;
      write_coef(3'd0, 16'd32768);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'd500;
      tick;
      in_data = 16'd999;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      total++;
      if (lat !== NT + 4) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, NT + 4); end
      for (int i = 0; i < 5; i++) begin
         tick;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'd500) begin
            bad++; $display("FAIL bp_hold%0d: valid=%0d ready=%0d data=%0d want 1/0/500", i, out_valid, in_ready, out_data);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release: in_ready=%0d out_valid=%0d want 1/0", in_ready, out_valid);
      end
      write_coef(3'd0, 16'd0);
      write_coef(3'd1, 16'd32768);
      run_sample(16'd1, 16'd500, "bp_no_accept");
   endtask

   task automatic test_mid_feed_reset;
      do_reset;
      write_coef(3'd0, 16'd32768);
      in_valid = 1'b1; in_data = 16'd123;
      tick;
      in_valid = 1'b0;
      tick;
      total++;
      if (mac_a !== 16'd123 || mac_b !== 16'd32768) begin
         bad++; $display("FAIL feed_k0: a=%0d b=%0d want 123/32768", mac_a, mac_b);
      end
      tick; tick; tick;
      rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, mac_clr} !== 3'b100 || mac_a !== 16'd0 || mac_b !== 16'd0 || out_data !== 16'd0) begin
         bad++; $display("FAIL midreset_outputs: rdy/vld/clr=%b a=%0d b=%0d out=%0d want 100/0/0/0",
                         {in_ready, out_valid, mac_clr}, mac_a, mac_b, out_data);
      end
      tick; tick;
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick;
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_result%0d: got %0d want 0", i, out_valid); end
      end
      write_coef(3'd0, 16'd32768);
      run_sample(16'd7, 16'd7, "after_reset");
   endtask

   initial begin
      test_reset;
      test_impulse;
      test_delay_line;
      test_round_sat;
      test_same_cycle;
      test_back_pressure;
      test_mid_feed_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
